// File: rtl/alu_arb_pkg.sv
// ============================================================================
// Module  : alu_arb_pkg
// Brief   : Shared ALU widths, op encoding and output-register states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_arb_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_SLT   = 4'h2,
        ALU_SLTU  = 4'h3,
        ALU_XOR   = 4'h4,
        ALU_OR    = 4'h5,
        ALU_AND   = 4'h6,
        ALU_SLL   = 4'h7,
        ALU_SRL   = 4'h8,
        ALU_SRA   = 4'h9,
        ALU_PASSB = 4'hA
    } alu_op_e;

    typedef enum logic [0:0] {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin arbiter with one-hot grant and grant index; the
//           ALU_ARB_FIXED_PRIO_EN macro selects a pointer-less fixed-priority
//           variant (lowest index wins).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

`ifdef ALU_ARB_FIXED_PRIO_EN

    // No pointer state here, so the clock, reset and advance strobe are idle.
    logic unused_ports;
    assign unused_ports = clk ^ rst_n ^ advance;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_idx = ID_W'(i);
            end
        end
        if (|req) begin
            grant[grant_idx] = 1'b1;
        end
    end

`else

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] next_ptr;
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;
    logic            found;

    // With no request the index rests on the pointer so the operand mux
    // still selects a defined requester.
    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            cand = sum[ID_W-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        if (grant_idx == ID_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= next_ptr;
        end
    end

`endif

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module  : alu_share_arbiter
// Brief   : Shares one combinational ALU among NUM_REQ requesters and returns
//           each result with its owner ID through a one-entry output register.
//           Define ALU_ARB_FIXED_PRIO_EN for fixed (lowest index) priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ALU_DATA_W-1:0] req_op_a_i,
    input  logic [NUM_REQ*ALU_DATA_W-1:0] req_op_b_i,
    input  logic [NUM_REQ*ALU_OP_W-1:0]   req_alu_op_i,
    output logic [ALU_DATA_W-1:0]         alu_operand_a_o,
    output logic [ALU_DATA_W-1:0]         alu_operand_b_o,
    output logic [ALU_OP_W-1:0]           alu_op_o,
    input  logic [ALU_DATA_W-1:0]         alu_data_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [ID_W-1:0]               rsp_id_o,
    output logic [ALU_DATA_W-1:0]         rsp_data_o
);

    rsp_state_e            rsp_state;
    logic [ALU_DATA_W-1:0] rsp_data;
    logic [ID_W-1:0]       rsp_id;

    logic                  can_accept;
    logic [NUM_REQ-1:0]    arb_req;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  transfer;

    assign can_accept = (rsp_state == RSP_EMPTY) || rsp_ready_i;

    // Requests are masked before arbitration so that a blocked cycle looks
    // like an idle one and the mux falls back to the pointer's requester.
    assign arb_req = req_valid_i & {NUM_REQ{can_accept}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .req       (arb_req),
        .advance   (transfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready_o = rst_ni ? grant : '0;
    assign transfer    = |req_ready_o;

    always_comb begin
        alu_operand_a_o = '0;
        alu_operand_b_o = '0;
        alu_op_o        = '0;
        if (rst_ni) begin
            alu_operand_a_o = req_op_a_i[ALU_DATA_W*int'(grant_idx) +: ALU_DATA_W];
            alu_operand_b_o = req_op_b_i[ALU_DATA_W*int'(grant_idx) +: ALU_DATA_W];
            alu_op_o        = req_alu_op_i[ALU_OP_W*int'(grant_idx) +: ALU_OP_W];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_state <= RSP_EMPTY;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            case (rsp_state)
                RSP_EMPTY: begin
                    if (transfer) begin
                        rsp_state <= RSP_FULL;
                        rsp_data  <= alu_data_i;
                        rsp_id    <= grant_idx;
                    end
                end
                RSP_FULL: begin
                    if (transfer) begin
                        rsp_data <= alu_data_i;
                        rsp_id   <= grant_idx;
                    end else if (rsp_ready_i) begin
                        rsp_state <= RSP_EMPTY;
                    end
                end
                default: begin
                    rsp_state <= RSP_EMPTY;
                end
            endcase
        end
    end

    assign rsp_valid_o = (rsp_state == RSP_FULL);
    assign rsp_data_o  = rsp_data;
    assign rsp_id_o    = rsp_id;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// Module  : tb_alu_share_arbiter
// Brief   : Directed and randomized bench for alu_share_arbiter against a
//           behavioural arbitration/response model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;
    import alu_arb_pkg::*;

    localparam int N   = 2;
    localparam int IDW = $clog2(N);

    logic             clk_i  = 1'b0;
    logic             rst_ni = 1'b0;
    logic [N-1:0]     req_valid_i;
    logic [N-1:0]     req_ready_o;
    logic [N*32-1:0]  req_op_a_i;
    logic [N*32-1:0]  req_op_b_i;
    logic [N*4-1:0]   req_alu_op_i;
    logic [31:0]      alu_operand_a_o;
    logic [31:0]      alu_operand_b_o;
    logic [3:0]       alu_op_o;
    logic [31:0]      alu_data_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [IDW-1:0]   rsp_id_o;
    logic [31:0]      rsp_data_o;

    always #5 clk_i = ~clk_i;

    alu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_op_a_i      (req_op_a_i),
        .req_op_b_i      (req_op_b_i),
        .req_alu_op_i    (req_alu_op_i),
        .alu_operand_a_o (alu_operand_a_o),
        .alu_operand_b_o (alu_operand_b_o),
        .alu_op_o        (alu_op_o),
        .alu_data_i      (alu_data_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_id_o        (rsp_id_o),
        .rsp_data_o      (rsp_data_o)
    );

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return {31'b0, ($signed(a) < $signed(b))};
            4'h3:    return {31'b0, (a < b)};
            4'h4:    return a ^ b;
            4'h5:    return a | b;
            4'h6:    return a & b;
            4'h7:    return a << b[4:0];
            4'h8:    return a >> b[4:0];
            4'h9:    return 32'($signed(a) >>> b[4:0]);
            4'hA:    return b;
            default: return 32'h0;
        endcase
    endfunction

    // Stand-in for the shared combinational ALU.
    assign alu_data_i = alu_ref(alu_op_o, alu_operand_a_o, alu_operand_b_o);

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    logic        val   [N];
    logic [31:0] a_arr [N];
    logic [31:0] b_arr [N];
    logic [3:0]  op_arr[N];
    logic        rdy;

    logic        m_valid;
    logic [31:0] m_data;
    int          m_id;
    int          m_ptr;
    int          last_grant;

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid_i[k]          = val[k];
            req_op_a_i[32*k +: 32]  = a_arr[k];
            req_op_b_i[32*k +: 32]  = b_arr[k];
            req_alu_op_i[4*k +: 4]  = op_arr[k];
        end
        rsp_ready_i = rdy;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_ptr   = 0;
    endtask

    // One clock: check grant and ALU drive mid-cycle, then the response after the edge.
    task automatic step(input string tag);
        int w;
        int sel;
        int k;
        logic cana;
        drive();
        #1;
        cana = !m_valid || rdy;
        w    = -1;
        if (cana) begin
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (w < 0 && val[k]) w = k;
            end
        end
        sel = (w >= 0) ? w : m_ptr;
        check({tag, "_ready"}, 32'(req_ready_o), (w >= 0) ? 32'(1 << w) : 32'h0);
        check({tag, "_alu_a"}, alu_operand_a_o, a_arr[sel]);
        check({tag, "_alu_b"}, alu_operand_b_o, b_arr[sel]);
        check({tag, "_alu_op"}, 32'(alu_op_o), 32'(op_arr[sel]));
        @(posedge clk_i);
        #1;
        if (w >= 0) begin
            m_valid = 1'b1;
            m_data  = alu_ref(op_arr[w], a_arr[w], b_arr[w]);
            m_id    = w;
`ifndef ALU_ARB_FIXED_PRIO_EN
            m_ptr   = (w + 1) % N;
`endif
            val[w]  = 1'b0;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        last_grant = w;
        check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'(m_valid));
        check({tag, "_rsp_data"}, rsp_data_o, m_data);
        check({tag, "_rsp_id"}, 32'(rsp_id_o), 32'(m_id));
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        check("rst_valid", 32'(rsp_valid_o), 32'h0);
        check("rst_ready", 32'(req_ready_o), 32'h0);
        check("rst_alu_a", alu_operand_a_o, 32'h0);
        @(posedge clk_i);
        #1;
        check("rst_data", rsp_data_o, 32'h0);
        check("rst_id", 32'(rsp_id_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    logic [31:0] snap_data;
    logic [31:0] snap_id;

    initial begin
        for (int k = 0; k < N; k++) begin
            val[k] = 1'b0; a_arr[k] = '0; b_arr[k] = '0; op_arr[k] = '0;
        end
        rdy = 1'b1;
        last_grant = -1;
        model_reset();
        drive();
        #3;
        do_reset();

        // Single ADD from requester 0
        val[0] = 1'b1; a_arr[0] = 32'd5; b_arr[0] = 32'd3; op_arr[0] = ALU_ADD;
        step("t1");
        check("t1_data_const", rsp_data_o, 32'd8);
        check("t1_id_const", 32'(rsp_id_o), 32'd0);

        // Tie between SUB and SLTU from a fresh pointer
        do_reset();
        val[0] = 1'b1; a_arr[0] = 32'd3; b_arr[0] = 32'd5; op_arr[0] = ALU_SUB;
        val[1] = 1'b1; a_arr[1] = 32'd3; b_arr[1] = 32'd5; op_arr[1] = ALU_SLTU;
        step("t2a");
        check("t2a_grant", 32'(last_grant), 32'd0);
        check("t2a_data_const", rsp_data_o, 32'hFFFF_FFFE);
        step("t2b");
        check("t2b_grant", 32'(last_grant), 32'd1);
        check("t2b_data_const", rsp_data_o, 32'd1);

        // Continuous contention
        for (int i = 0; i < 6; i++) begin
            val[0] = 1'b1;
            val[1] = 1'b1;
            step("t3");
`ifdef ALU_ARB_FIXED_PRIO_EN
            check("t3_grant", 32'(last_grant), 32'd0);
`else
            check("t3_grant", 32'(last_grant), 32'(i % 2));
`endif
        end

        // Back-pressure while FULL
        val[0] = 1'b0;
        val[1] = 1'b1; a_arr[1] = 32'h1234_0000; b_arr[1] = 32'h0000_5678; op_arr[1] = ALU_OR;
        rdy = 1'b0;
        snap_data = rsp_data_o;
        snap_id   = 32'(rsp_id_o);
        for (int i = 0; i < 3; i++) begin
            step("t4_stall");
            check("t4_hold_data", rsp_data_o, snap_data);
            check("t4_hold_id", 32'(rsp_id_o), snap_id);
        end
        rdy = 1'b1;
        step("t4_go");
        check("t4_grant", 32'(last_grant), 32'd1);
        check("t4_data_const", rsp_data_o, 32'h1234_5678);

        // Asynchronous reset mid-cycle while FULL with requests pending
        val[0] = 1'b1; val[1] = 1'b1;
        drive();
        #2;
        rst_ni = 1'b0;
        #1;
        check("t5_async_valid", 32'(rsp_valid_o), 32'h0);
        check("t5_async_ready", 32'(req_ready_o), 32'h0);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        model_reset();
        @(negedge clk_i);
        step("t5");
        check("t5_grant", 32'(last_grant), 32'd0);

        // Randomized traffic with random consumer back-pressure
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!val[k] && ($urandom_range(0, 99) < 60)) begin
                    val[k]    = 1'b1;
                    a_arr[k]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                    b_arr[k]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                    op_arr[k] = 4'($urandom_range(0, 11));
                end
            end
            rdy = ($urandom_range(0, 99) < 70);
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
